// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Host-side initiator for a 4-entry byte store. The store has a level-sensitive
// store strobe and a combinational read path on its address, so this block
// sequences every access into safely timed cycles:
//   - writes: address/data setup, STROBE_CYCLES of store high, HOLD_CYCLES of
//     address/data hold, then a one-cycle wr_done pulse in the last hold cycle;
//   - reads: one settle cycle, then the byte is offered on a valid/ready channel;
//   - dump: sweeps addresses 0..3 as four read beats, honouring backpressure.
// One command is in flight at a time. Every output is driven from a register.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   cmd_valid/ready host command handshake (ready only while idle)
//   cmd_write       1 = write, 0 = read
//   cmd_dump        1 = dump all four bytes (overrides cmd_write/cmd_addr)
//   cmd_addr/data   target address and write byte
//   rsp_valid/ready read-byte handshake
//   rsp_data/addr   read byte and the address it came from
//   rsp_last        final byte of a read or dump
//   wr_done         one-cycle pulse when a write sequence completes
//   mem_data/store/addr  pins to the memory
//   mem_q           memory read data (combinational on mem_addr)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_dump,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_addr,
    output logic       rsp_last,
    output logic       wr_done,
    output logic [7:0] mem_data,
    output logic       mem_store,
    output logic [1:0] mem_addr,
    input  logic [7:0] mem_q
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SETUP  = 3'd1,
        ST_W_STROBE = 3'd2,
        ST_W_HOLD   = 3'd3,
        ST_R_SETTLE = 3'd4,
        ST_R_OUT    = 3'd5
    } state_t;

    // Counters hold "cycles remaining minus one" so a phase ends when they hit zero.
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 32'd1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 32'd1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_dump;
    logic       w_dump_nxt;

    logic       r_cmd_ready;
    logic       r_mem_store;
    logic [1:0] r_mem_addr;
    logic [1:0] w_mem_addr_nxt;
    logic [7:0] r_mem_data;
    logic [7:0] w_mem_data_nxt;
    logic       r_wr_done;
    logic       r_rsp_valid;
    logic       w_rsp_valid_nxt;
    logic [7:0] r_rsp_data;
    logic [7:0] w_rsp_data_nxt;
    logic [1:0] r_rsp_addr;
    logic [1:0] w_rsp_addr_nxt;
    logic       r_rsp_last;
    logic       w_rsp_last_nxt;

    logic       w_accept;

    assign w_accept = cmd_valid & r_cmd_ready;

    // Next-state, counter and next-output-value decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_dump_nxt      = r_dump;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_last_nxt  = r_rsp_last;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = 4'd0;
                    if (cmd_dump) begin
                        w_dump_nxt     = 1'b1;
                        w_mem_addr_nxt = 2'd0;
                        w_state_nxt    = ST_R_SETTLE;
                    end else if (cmd_write) begin
                        w_dump_nxt     = 1'b0;
                        w_mem_addr_nxt = cmd_addr;
                        w_mem_data_nxt = cmd_data;
                        w_state_nxt    = ST_W_SETUP;
                    end else begin
                        w_dump_nxt     = 1'b0;
                        w_mem_addr_nxt = cmd_addr;
                        w_state_nxt    = ST_R_SETTLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_W_SETUP: begin
                w_state_nxt = ST_W_STROBE;
                w_cnt_nxt   = STROBE_LOAD;
            end

            ST_W_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_W_HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_W_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_R_SETTLE: begin
                // mem_q has had a full cycle to settle on r_mem_addr.
                w_rsp_data_nxt  = mem_q;
                w_rsp_addr_nxt  = r_mem_addr;
                w_rsp_last_nxt  = (~r_dump) | (r_mem_addr == 2'd3);
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_R_OUT;
                w_cnt_nxt       = 4'd0;
            end

            ST_R_OUT: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cnt_nxt       = 4'd0;
                    if (r_dump && (r_rsp_addr != 2'd3)) begin
                        w_mem_addr_nxt = r_rsp_addr + 2'd1;
                        w_state_nxt    = ST_R_SETTLE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_R_OUT;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_cnt_nxt       = 4'd0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; store/ready/done follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_dump      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_addr  <= 2'd0;
            r_mem_data  <= 8'd0;
            r_wr_done   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_rsp_addr  <= 2'd0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dump      <= w_dump_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_mem_store <= (w_state_nxt == ST_W_STROBE);
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_wr_done   <= (w_state_nxt == ST_W_HOLD) && (w_cnt_nxt == 4'd0);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign mem_store = r_mem_store;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign wr_done   = r_wr_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_last  = r_rsp_last;

endmodule
